// File: rtl/traffic_req_encoder.sv
// Front-end for the traffic light controller: synchronises and debounces the
// raw override buttons and maintenance switch, priority-encodes presses into
// a request code, and holds each code for a fixed window followed by a gap.
module traffic_req_encoder #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 3
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn_red,
    input  logic       btn_yel,
    input  logic       btn_grn,
    input  logic       maint,
    output logic [1:0] req,
    output logic       req_valid,
    output logic       en,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYC);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    // Request codes; bit order of the input vectors is red, yellow, green, maint.
    localparam logic [1:0] CODE_RED  = 2'b00;
    localparam logic [1:0] CODE_YEL  = 2'b01;
    localparam logic [1:0] CODE_GRN  = 2'b10;
    localparam logic [1:0] CODE_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [2:0]    pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t        state_q, state_d;
    logic [1:0]    req_q, req_d;
    logic          req_valid_q, req_valid_d;
    logic          en_q, en_d;
    logic [2:0]    press;
    logic          maint_on;

    assign raw = {maint, btn_grn, btn_yel, btn_red};

    // Two-flop synchroniser for every raw asynchronous input.
    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles of disagreement; flip the level once the count has reached the limit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press    = deb_d[2:0] & ~deb_q[2:0];
        maint_on = deb_d[3];
    end

    // Request FSM: select by priority in IDLE, hold the code, then insert one gap cycle.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        req_d       = req_q;
        req_valid_d = 1'b0;
        pend_d      = pend_q | press;
        en_d        = ~maint_on;
        case (state_q)
            IDLE: begin
                req_d = CODE_NONE;
                if (pend_q != 3'b000) begin
                    state_d     = HOLD;
                    hold_d      = HOLD_LOAD;
                    req_valid_d = 1'b1;
                    if (pend_q[0]) begin
                        req_d     = CODE_RED;
                        pend_d[0] = press[0];
                    end else if (pend_q[2]) begin
                        req_d     = CODE_GRN;
                        pend_d[2] = press[2];
                    end else begin
                        req_d     = CODE_YEL;
                        pend_d[1] = press[1];
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = GAP;
                    req_d   = CODE_NONE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                req_d   = CODE_NONE;
            end
            default: begin
                state_d = IDLE;
                req_d   = CODE_NONE;
            end
        endcase
        if (maint_on) begin
            state_d     = IDLE;
            hold_d      = '0;
            req_d       = CODE_NONE;
            req_valid_d = 1'b0;
            pend_d      = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (res) begin
            deb_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q      <= '0;
            hold_q      <= '0;
            state_q     <= IDLE;
            req_q       <= CODE_NONE;
            req_valid_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            deb_q       <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            en_q        <= en_d;
        end
    end

    assign req       = req_q;
    assign req_valid = req_valid_q;
    assign en        = en_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_traffic_req_encoder.sv
// Self-checking bench for traffic_req_encoder: expected request events are
// queued with their expected cycle when a button is driven and compared when
// req_valid is seen.
module tb_traffic_req_encoder;

    logic       clk = 1'b0;
    logic       res;
    logic       btn_red, btn_yel, btn_grn, maint;
    logic [1:0] req;
    logic       req_valid, en, busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    traffic_req_encoder #(.DEBOUNCE_CYC(4), .HOLD_CYC(3)) dut (
        .clk       (clk),
        .res       (res),
        .btn_red   (btn_red),
        .btn_yel   (btn_yel),
        .btn_grn   (btn_grn),
        .maint     (maint),
        .req       (req),
        .req_valid (req_valid),
        .en        (en),
        .busy      (busy)
    );

    // Free-running clock and an edge counter used as the timeline.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        res = 1'b1; btn_red = 1'b0; btn_yel = 1'b0; btn_grn = 1'b0; maint = 1'b0;
        step();
        step();
        n_checks++;
        if (req !== 2'b11 || req_valid !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b en=%b busy=%b, expected req=11 valid=0 en=0 busy=0",
                     req, req_valid, en, busy);
        end
        n_checks++;
        if (dut.pend_q !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL reset_pending: got %b expected 000", dut.pend_q);
        end
        res = 1'b0;
        step();
        n_checks++;
        if (en !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL first_cycle_en: got %b expected 1", en);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (req !== 2'b11 || busy !== 1'b0 || en !== 1'b1 || req_valid !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL idle_state: got req=%b busy=%b en=%b valid=%b, expected req=11 busy=0 en=1 valid=0",
                         req, busy, en, req_valid);
            end
        end
    endtask

    task automatic test_green();
        int   k;
        exp_t e;
        btn_grn = 1'b1;
        k = cyc + 1;
        e.code = 2'b10; e.at = k + 7;
        exp_q.push_back(e);
        for (int i = 0; i < 20; i++) begin
            step();
            if (cyc == k + 9) btn_grn = 1'b0;
            if (req_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL green_unexpected_valid: got req=%b at cycle %0d, expected no event", req, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (req !== e.code || cyc != e.at) begin
                        n_fails++;
                        $display("[TB] FAIL green_event: got req=%b at cycle %0d, expected req=%b at cycle %0d",
                                 req, cyc, e.code, e.at);
                    end
                end
            end
            if (cyc >= k + 7 && cyc <= k + 9) begin
                n_checks++;
                if (req !== 2'b10 || busy !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL green_hold: cycle %0d got req=%b busy=%b, expected req=10 busy=1", cyc, req, busy);
                end
            end
            if (cyc == k + 10) begin
                n_checks++;
                if (req !== 2'b11 || busy !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL green_gap: got req=%b busy=%b, expected req=11 busy=1", req, busy);
                end
            end
            if (cyc == k + 11) begin
                n_checks++;
                if (req !== 2'b11 || busy !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL green_idle: got req=%b busy=%b, expected req=11 busy=0", req, busy);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL green_drained: %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        int nvalid = 0;
        int nbad   = 0;
        btn_red = 1'b1;
        idle(3);
        btn_red = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (req_valid) nvalid++;
            if (req !== 2'b11 || dut.pend_q !== 3'b000) nbad++;
        end
        n_checks++;
        if (nvalid != 0) begin
            n_fails++;
            $display("[TB] FAIL glitch_valid: got %0d pulses expected 0", nvalid);
        end
        n_checks++;
        if (nbad != 0) begin
            n_fails++;
            $display("[TB] FAIL glitch_idle: got %0d cycles with req!=11 or pending set, expected 0", nbad);
        end
    endtask

    task automatic test_simultaneous();
        int   k;
        int   nvalid = 0;
        exp_t e;
        logic [1:0] want;
        btn_red = 1'b1;
        btn_yel = 1'b1;
        k = cyc + 1;
        e.code = 2'b00; e.at = k + 7;  exp_q.push_back(e);
        e.code = 2'b01; e.at = k + 12; exp_q.push_back(e);
        for (int i = 0; i < 25; i++) begin
            step();
            if (cyc == k + 9) begin
                btn_red = 1'b0;
                btn_yel = 1'b0;
            end
            if (req_valid) begin
                nvalid++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL simul_unexpected_valid: got req=%b at cycle %0d, expected no event", req, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (req !== e.code || cyc != e.at) begin
                        n_fails++;
                        $display("[TB] FAIL simul_event: got req=%b at cycle %0d, expected req=%b at cycle %0d",
                                 req, cyc, e.code, e.at);
                    end
                end
            end
            if (cyc >= k + 7 && cyc <= k + 15) begin
                if (cyc <= k + 9)       want = 2'b00;
                else if (cyc <= k + 11) want = 2'b11;
                else if (cyc <= k + 14) want = 2'b01;
                else                    want = 2'b11;
                n_checks++;
                if (req !== want) begin
                    n_fails++;
                    $display("[TB] FAIL simul_sequence: cycle %0d got req=%b expected %b", cyc, req, want);
                end
            end
        end
        n_checks++;
        if (nvalid != 2 || exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL simul_count: got %0d pulses (%0d outstanding), expected 2 (0 outstanding)",
                     nvalid, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_maint();
        int   k;
        exp_t e;
        btn_grn = 1'b1;
        k = cyc + 1;
        e.code = 2'b10; e.at = k + 7;
        exp_q.push_back(e);
        for (int i = 0; i < 40; i++) begin
            step();
            if (req_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL maint_unexpected_valid: got req=%b at cycle %0d, expected no event", req, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (req !== e.code || cyc != e.at) begin
                        n_fails++;
                        $display("[TB] FAIL maint_event: got req=%b at cycle %0d, expected req=%b at cycle %0d",
                                 req, cyc, e.code, e.at);
                    end
                end
            end
            if (cyc == k + 7) begin
                n_checks++;
                if (req !== 2'b10 || en !== 1'b1 || dut.pend_q !== 3'b001) begin
                    n_fails++;
                    $display("[TB] FAIL maint_pre: got req=%b en=%b pend=%b, expected req=10 en=1 pend=001",
                             req, en, dut.pend_q);
                end
            end
            if (cyc == k + 8) begin
                n_checks++;
                if (req !== 2'b11 || en !== 1'b0 || busy !== 1'b0 || dut.pend_q !== 3'b000) begin
                    n_fails++;
                    $display("[TB] FAIL maint_abort: got req=%b en=%b busy=%b pend=%b, expected req=11 en=0 busy=0 pend=000",
                             req, en, busy, dut.pend_q);
                end
            end
            if (cyc > k + 8 && cyc <= k + 18) begin
                n_checks++;
                if (req !== 2'b11 || en !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL maint_active: cycle %0d got req=%b en=%b, expected req=11 en=0", cyc, req, en);
                end
            end
            if (cyc == k + 19) begin
                n_checks++;
                if (en !== 1'b1 || req !== 2'b11) begin
                    n_fails++;
                    $display("[TB] FAIL maint_release: got en=%b req=%b, expected en=1 req=11", en, req);
                end
            end
            if (cyc == k)     btn_red = 1'b1;
            if (cyc == k + 1) maint   = 1'b1;
            if (cyc == k + 9) btn_grn = 1'b0;
            if (cyc == k + 12) begin
                maint   = 1'b0;
                btn_red = 1'b0;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || req !== 2'b11 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL maint_no_replay: outstanding=%0d req=%b busy=%b, expected 0 11 0",
                     exp_q.size(), req, busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int   k;
        exp_t e;
        btn_grn = 1'b1;
        k = cyc + 1;
        e.code = 2'b10; e.at = k + 7;
        exp_q.push_back(e);
        for (int i = 0; i < 30; i++) begin
            step();
            if (req_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL rstmid_unexpected_valid: got req=%b at cycle %0d, expected no event", req, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (req !== e.code || cyc != e.at) begin
                        n_fails++;
                        $display("[TB] FAIL rstmid_event: got req=%b at cycle %0d, expected req=%b at cycle %0d",
                                 req, cyc, e.code, e.at);
                    end
                end
            end
            if (cyc == k + 7) begin
                n_checks++;
                if (dut.pend_q !== 3'b001) begin
                    n_fails++;
                    $display("[TB] FAIL rstmid_pending: got %b expected 001", dut.pend_q);
                end
            end
            if (cyc == k + 8) begin
                n_checks++;
                if (req !== 2'b11 || en !== 1'b0 || busy !== 1'b0 || req_valid !== 1'b0 || dut.pend_q !== 3'b000) begin
                    n_fails++;
                    $display("[TB] FAIL rstmid_state: got req=%b en=%b busy=%b valid=%b pend=%b, expected 11 0 0 0 000",
                             req, en, busy, req_valid, dut.pend_q);
                end
            end
            if (cyc == k + 9) begin
                n_checks++;
                if (en !== 1'b1 || req !== 2'b11 || busy !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL rstmid_release: got en=%b req=%b busy=%b, expected 1 11 0", en, req, busy);
                end
            end
            if (cyc == k) btn_red = 1'b1;
            if (cyc == k + 7) begin
                res     = 1'b1;
                btn_grn = 1'b0;
                btn_red = 1'b0;
            end
            if (cyc == k + 8) res = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL rstmid_drained: %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        idle(4);
        test_green();
        idle(12);
        test_glitch();
        idle(12);
        test_simultaneous();
        idle(12);
        test_maint();
        idle(12);
        test_reset_mid();
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
